// File: rtl/devil_pkg.sv
// Shared types and constants for the ACE snoop initiator: FSM states,
// status register layout, CRRESP bit positions and ACSNOOP opcodes.
package devil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_CR = 3'd2,
    ST_WAIT_CD = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Status register bit positions
  localparam int unsigned STAT_DONE       = 0;
  localparam int unsigned STAT_BUSY       = 1;
  localparam int unsigned STAT_TIMEOUT    = 2;
  localparam int unsigned STAT_LAST_ERR   = 3;
  localparam int unsigned STAT_CRRESP_LSB = 4;
  localparam int unsigned STAT_BEATS_LSB  = 9;
  localparam int unsigned STAT_BEATS_W    = 3;

  localparam int unsigned CRRESP_W  = 5;
  localparam int unsigned ACSNOOP_W = 4;
  localparam int unsigned ACPROT_W  = 3;

  // CRRESP bit positions
  localparam int unsigned CRRESP_DATA_TRANSFER = 0;
  localparam int unsigned CRRESP_ERROR         = 1;
  localparam int unsigned CRRESP_PASS_DIRTY    = 2;
  localparam int unsigned CRRESP_IS_SHARED     = 3;
  localparam int unsigned CRRESP_WAS_UNIQUE    = 4;

  // ACSNOOP opcodes
  localparam logic [ACSNOOP_W-1:0] ACSNOOP_READ_ONCE        = 4'b0000;
  localparam logic [ACSNOOP_W-1:0] ACSNOOP_READ_SHARED      = 4'b0001;
  localparam logic [ACSNOOP_W-1:0] ACSNOOP_READ_CLEAN       = 4'b0010;
  localparam logic [ACSNOOP_W-1:0] ACSNOOP_READ_NOT_SH_DIRTY = 4'b0011;
  localparam logic [ACSNOOP_W-1:0] ACSNOOP_READ_UNIQUE      = 4'b0111;
  localparam logic [ACSNOOP_W-1:0] ACSNOOP_CLEAN_SHARED     = 4'b1000;
  localparam logic [ACSNOOP_W-1:0] ACSNOOP_CLEAN_INVALID    = 4'b1001;
  localparam logic [ACSNOOP_W-1:0] ACSNOOP_MAKE_INVALID     = 4'b1101;
  localparam logic [ACSNOOP_W-1:0] ACSNOOP_DVM_COMPLETE     = 4'b1110;
  localparam logic [ACSNOOP_W-1:0] ACSNOOP_DVM_MESSAGE      = 4'b1111;

  // Low byte of the control register
  typedef struct packed {
    logic [ACPROT_W-1:0]  acprot;
    logic [ACSNOOP_W-1:0] acsnoop;
    logic                 en;
  } ctrl_t;

  function automatic logic crresp_has_data(input logic [CRRESP_W-1:0] resp);
    return resp[CRRESP_DATA_TRANSFER];
  endfunction

endpackage

// File: rtl/devil_snoop_master.sv
// Register-driven ACE snoop initiator: issues one AC request per enable,
// collects the CR response and optional CD line, and reports status/latency.
module devil_snoop_master
  import devil_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_ACE_DATA_WIDTH   = 128,
  parameter int unsigned C_ACE_ADDR_WIDTH   = 44,
  parameter int unsigned CD_BEATS           = 4
) (
  input  logic                                   ace_aclk,
  input  logic                                   ace_areset,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          i_control_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          i_addr_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          i_timeout_reg,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          o_status_reg,
  output logic [31:0]                            o_latency,
  output logic [CD_BEATS*C_ACE_DATA_WIDTH-1:0]   o_cd_line,
  output logic                                   o_acvalid,
  input  logic                                   i_acready,
  output logic [C_ACE_ADDR_WIDTH-1:0]            o_acaddr,
  output logic [3:0]                             o_acsnoop,
  output logic [2:0]                             o_acprot,
  input  logic                                   i_crvalid,
  output logic                                   o_crready,
  input  logic [4:0]                             i_crresp,
  input  logic                                   i_cdvalid,
  output logic                                   o_cdready,
  input  logic [C_ACE_DATA_WIDTH-1:0]            i_cddata,
  input  logic                                   i_cdlast
);

  localparam int unsigned RW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned DW = C_ACE_DATA_WIDTH;
  localparam int unsigned AW = C_ACE_ADDR_WIDTH;
  localparam int unsigned LW = CD_BEATS * C_ACE_DATA_WIDTH;
  localparam int unsigned BW = $clog2(CD_BEATS + 1);

  state_e                state_q;
  logic                  acvalid_q;
  logic [AW-1:0]         acaddr_q;
  logic [ACSNOOP_W-1:0]  acsnoop_q;
  logic [ACPROT_W-1:0]   acprot_q;
  logic                  crready_q;
  logic                  cdready_q;
  logic                  done_q;
  logic                  busy_q;
  logic                  timeout_q;
  logic                  last_err_q;
  logic [CRRESP_W-1:0]   crresp_q;
  logic [BW-1:0]         beats_q;
  logic [31:0]           latency_q;
  logic [LW-1:0]         line_q;
  logic [RW-1:0]         tmo_q;

  ctrl_t                 ctrl_c;
  logic [RW-1:0]         tmo_inc_c;
  logic                  tmo_hit_c;
  logic [31:0]           lat_inc_c;
  logic                  last_slot_c;
  logic [RW-1:0]         status_c;
  logic                  unused_ctrl_c;

  assign ctrl_c        = ctrl_t'(i_control_reg[7:0]);
  assign unused_ctrl_c = ^i_control_reg[RW-1:8];

  // Watchdog: fires when the cycle count in the current wait state reaches the limit
  assign tmo_inc_c   = tmo_q + RW'(1);
  assign tmo_hit_c   = (i_timeout_reg != '0) && (tmo_inc_c == i_timeout_reg);
  assign lat_inc_c   = (&latency_q) ? latency_q : latency_q + 32'd1;
  assign last_slot_c = (beats_q == BW'(CD_BEATS - 1));

  always_ff @(posedge ace_aclk or posedge ace_areset) begin
    if (ace_areset) begin
      state_q    <= ST_IDLE;
      acvalid_q  <= 1'b0;
      acaddr_q   <= '0;
      acsnoop_q  <= '0;
      acprot_q   <= '0;
      crready_q  <= 1'b0;
      cdready_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      last_err_q <= 1'b0;
      crresp_q   <= '0;
      beats_q    <= '0;
      latency_q  <= '0;
      line_q     <= '0;
      tmo_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!ctrl_c.en) begin
            done_q <= 1'b0;
          end else if (!done_q) begin
            state_q    <= ST_ISSUE;
            acvalid_q  <= 1'b1;
            busy_q     <= 1'b1;
            acaddr_q   <= AW'(i_addr_reg);
            acsnoop_q  <= ctrl_c.acsnoop;
            acprot_q   <= ctrl_c.acprot;
            timeout_q  <= 1'b0;
            last_err_q <= 1'b0;
            crresp_q   <= '0;
            beats_q    <= '0;
            latency_q  <= '0;
            line_q     <= '0;
          end
        end

        // Request stays up until accepted; no watchdog here
        ST_ISSUE: begin
          if (i_acready) begin
            acvalid_q <= 1'b0;
            crready_q <= 1'b1;
            latency_q <= '0;
            tmo_q     <= '0;
            state_q   <= ST_WAIT_CR;
          end
        end

        ST_WAIT_CR: begin
          latency_q <= lat_inc_c;
          if (i_crvalid) begin
            crready_q <= 1'b0;
            crresp_q  <= i_crresp;
            tmo_q     <= '0;
            if (crresp_has_data(i_crresp)) begin
              cdready_q <= 1'b1;
              state_q   <= ST_WAIT_CD;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end
          end else if (tmo_hit_c) begin
            crready_q <= 1'b0;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_DONE;
          end else begin
            tmo_q <= tmo_inc_c;
          end
        end

        ST_WAIT_CD: begin
          if (i_cdvalid) begin
            for (int unsigned b = 0; b < CD_BEATS; b++) begin
              if (beats_q == BW'(b)) line_q[b*DW +: DW] <= i_cddata;
            end
            if (beats_q != BW'(CD_BEATS)) beats_q <= beats_q + BW'(1);
          end
          // Line ends on the flagged beat or the final slot; a mismatch is a framing error
          if (i_cdvalid && (i_cdlast || last_slot_c)) begin
            cdready_q  <= 1'b0;
            last_err_q <= i_cdlast ^ last_slot_c;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= ST_DONE;
          end else if (tmo_hit_c) begin
            cdready_q <= 1'b0;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_DONE;
          end else begin
            tmo_q <= tmo_inc_c;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q   <= ST_IDLE;
          acvalid_q <= 1'b0;
          crready_q <= 1'b0;
          cdready_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    status_c                                     = '0;
    status_c[STAT_DONE]                          = done_q;
    status_c[STAT_BUSY]                          = busy_q;
    status_c[STAT_TIMEOUT]                       = timeout_q;
    status_c[STAT_LAST_ERR]                      = last_err_q;
    status_c[STAT_CRRESP_LSB +: CRRESP_W]        = crresp_q;
    status_c[STAT_BEATS_LSB +: STAT_BEATS_W]     = STAT_BEATS_W'(beats_q);
  end

  assign o_status_reg = status_c;
  assign o_latency    = latency_q;
  assign o_cd_line    = line_q;
  assign o_acvalid    = acvalid_q;
  assign o_acaddr     = acaddr_q;
  assign o_acsnoop    = acsnoop_q;
  assign o_acprot     = acprot_q;
  assign o_crready    = crready_q;
  assign o_cdready    = cdready_q;

endmodule
